// File: rtl/ntt_iterative.sv
// Iterative N-point cyclic NTT/INTT over Z_q with one butterfly per cycle and
// a bit-reversed coefficient register file; streams coefficients in and out.
module ntt_iterative #(
    parameter int N         = 8,
    parameter int Q         = 3329,
    parameter int W         = 12,
    parameter int OMEGA     = 749,
    parameter int OMEGA_INV = 3289,
    parameter int N_INV     = 2913
) (
    input  logic         clk,
    input  logic         r,
    input  logic         mode_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int LOG2N = $clog2(N);
    localparam int TWW   = (LOG2N > 1) ? LOG2N - 1 : 1;
    localparam logic [LOG2N-1:0] IDX_MAX = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] BF_MAX  = LOG2N'(N / 2 - 1);
    localparam logic [LOG2N-1:0] STG_MAX = LOG2N'(LOG2N - 1);

    generate
        if (N < 2 || N > 256 || (N & (N - 1)) != 0 || ((Q - 1) % N) != 0 ||
            Q >= (1 << W) || (1 << W) >= 2 * Q) begin : g_param_err
            $error("ntt_iterative: illegal N/Q/W parameter combination");
        end
    endgenerate

    typedef logic [N/2-1:0][W-1:0] tw_t;

    // Powers base^0 .. base^(N/2-1) mod Q, evaluated at elaboration.
    function automatic tw_t gen_tw(input int base);
        tw_t    t;
        longint p;
        p = 1;
        for (int k = 0; k < N / 2; k++) begin
            t[k] = W'(p);
            p    = (p * base) % Q;
        end
        return t;
    endfunction

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] y;
        for (int k = 0; k < LOG2N; k++) y[k] = x[LOG2N-1-k];
        return y;
    endfunction

    localparam tw_t TW_FWD = gen_tw(OMEGA);
    localparam tw_t TW_INV = gen_tw(OMEGA_INV);

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    state_t           state, state_nx;
    logic [LOG2N-1:0] idx, bf, stg;
    logic             mode;
    logic [W-1:0]     mem [N];

    logic [LOG2N-1:0] top, bot;
    logic [TWW-1:0]   tw_idx;
    logic [W-1:0]     tw, bf_a, bf_b, bf_t, bf_u, bf_v, ld_val, rd, scaled;
    logic [2*W-1:0]   bf_prod, sc_prod;
    logic [W:0]       bf_sum;
    logic             last_bf;

    assign last_bf = (stg == STG_MAX) && (bf == BF_MAX);
    assign ld_val  = (in_data >= W'(Q)) ? in_data - W'(Q) : in_data;
    assign rd      = mem[idx];
    assign sc_prod = {{W{1'b0}}, rd} * (2*W)'(N_INV);
    assign scaled  = W'(sc_prod % (2*W)'(Q));

    // Butterfly addressing: stage s pairs (base, base + 2^s), twiddle exponent j*N/2^(s+1).
    always_comb begin
        int s, j, base;
        s       = int'(stg);
        j       = int'(bf) & ((1 << s) - 1);
        base    = ((int'(bf) >> s) << (s + 1)) | j;
        top     = LOG2N'(base);
        bot     = LOG2N'(base + (1 << s));
        tw_idx  = TWW'(j << (LOG2N - 1 - s));
        tw      = mode ? TW_INV[tw_idx] : TW_FWD[tw_idx];
        bf_a    = mem[top];
        bf_b    = mem[bot];
        bf_prod = {{W{1'b0}}, bf_b} * {{W{1'b0}}, tw};
        bf_t    = W'(bf_prod % (2*W)'(Q));
        bf_sum  = {1'b0, bf_a} + {1'b0, bf_t};
        bf_u    = (bf_sum >= (W+1)'(Q)) ? W'(bf_sum - (W+1)'(Q)) : W'(bf_sum);
        bf_v    = (bf_a >= bf_t) ? bf_a - bf_t
                                 : W'({1'b0, bf_a} + (W+1)'(Q) - {1'b0, bf_t});
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        busy      = 1'b0;
        case (state)
            LOAD: begin
                in_ready = !r;
                if (in_valid && idx == IDX_MAX) state_nx = COMPUTE;
            end
            COMPUTE: begin
                busy = 1'b1;
                if (last_bf) state_nx = UNLOAD;
            end
            UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = (idx == IDX_MAX);
                out_data  = mode ? scaled : rd;
                if (out_ready && idx == IDX_MAX) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state <= LOAD;
            idx   <= '0;
            bf    <= '0;
            stg   <= '0;
            mode  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                LOAD: if (in_valid) begin
                    if (idx == '0) mode <= mode_in;
                    idx <= idx + 1'b1;
                end
                COMPUTE: if (bf == BF_MAX) begin
                    bf  <= '0;
                    stg <= (stg == STG_MAX) ? '0 : stg + 1'b1;
                end else begin
                    bf <= bf + 1'b1;
                end
                UNLOAD: if (out_ready) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    // Register file survives reset; only the frame bookkeeping is cleared.
    always_ff @(posedge clk) begin
        if (!r) begin
            if (state == LOAD && in_valid) begin
                mem[bitrev(idx)] <= ld_val;
            end else if (state == COMPUTE) begin
                mem[top] <= bf_u;
                mem[bot] <= bf_v;
            end
        end
    end

endmodule

// File: doc/ntt_iterative.md
# ntt_iterative

Parametrised N-point cyclic NTT/INTT core over Z_q, replacing the fixed 8-point fully unrolled pipeline in the Kyber datapath. It uses one modular butterfly and an internal coefficient register file. Coefficients stream in and out one per cycle over valid/ready handshakes, and each transform's direction is selected at run time. It sits between the polynomial sampler/loader and the pointwise-multiply stage.

## Interface
- N, 8: transform size; power of 2, 2..256, must divide Q-1; elaboration error otherwise. LOG2N is derived.
- Q, 3329: modulus.
- W, 12: coefficient width; requires Q < 2^W < 2Q.
- OMEGA, 749: primitive N-th root of unity mod Q.
- OMEGA_INV, 3289: OMEGA^-1 mod Q.
- N_INV, 2913: N^-1 mod Q.
- clk  in  1  clock; all state updates on the rising edge.
- r  in  1  reset; one clock, synchronous, active-high.
- mode_in  in  1  0 = forward NTT, 1 = inverse; sampled only with the first accepted coefficient.
- in_valid  in  1  in_data valid.
- in_ready  out  1  core accepts a coefficient this cycle.
- in_data  in  W  input coefficient, natural order, index 0 first.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  W  result coefficient, natural order, index 0 first, always < Q.
- out_last  out  1  high with the coefficient of index N-1.
- busy  out  1  high in COMPUTE or UNLOAD.

## Operation
- Forward: X[k] = sum_j a[j]*OMEGA^(j*k) mod Q.
- Inverse: a[j] = N_INV * sum_k X[k]*OMEGA_INV^(j*k) mod Q.
- FSM states: LOAD -> COMPUTE -> UNLOAD -> LOAD. Reset enters LOAD.
- LOAD:
  - in_ready = 1 (0 while r is high).
  - Each in_valid&in_ready stores one coefficient and increments the load index.
  - Inputs >= Q are reduced on store: x-Q.
  - mode_in is latched on index 0 only; later changes in the same frame are ignored.
  - The N-th accept moves to COMPUTE. The implementation may store at bit-reversed addresses.
- COMPUTE:
  - LOG2N stages x N/2 butterflies, exactly one butterfly per cycle.
  - Operands are read and results written back in the same cycle.
  - The twiddle table for OMEGA or OMEGA_INV is built at elaboration by a constant function.
  - No mid-frame stalls. in_ready = 0; in_valid is ignored.
- Butterfly arithmetic:
  - t = b*w mod Q, using the full 2W-bit product then reduction.
  - u = a+t, minus Q if >= Q.
  - v = a-t, plus Q if negative.
  - All stored values are < Q.
- UNLOAD:
  - out_valid = 1; out_data = coefficient at the current index.
  - In inverse mode out_data is scaled by N_INV mod Q on the output path.
  - The index advances on out_valid&out_ready.
  - out_data and out_last stay stable while out_ready = 0.
  - Acceptance of index N-1 moves to LOAD.
- Reset mid-frame (any state): the frame is discarded, counters clear, and the FSM returns to LOAD. The register file is not cleared.

## Timing
- Reset values: in_ready 0 during the reset cycle, 1 from the first cycle with r low. out_valid 0, out_last 0, busy 0, out_data 0.
- Let the N-th input accept occur at cycle T:
  - COMPUTE spans T+1 .. T+LOG2N*N/2.
  - out_valid first high at cycle T+1+LOG2N*N/2 (N=8: T+13).
  - busy is high from T+1.
- With out_ready held at 1, the N outputs appear on N consecutive cycles. out_last is high on the final one.
- in_ready returns to 1 the cycle after the last output accept. Frames do not overlap.
- Throughput with no stalls: 2N + LOG2N*N/2 cycles per frame (N=8: 28).
- Back-to-back frames: a frame whose in_valid is held high loses no cycles.
- in_valid may be high when in_ready is low; no data is taken.

## Test plan
- Forward impulse: mode 0, input [1,0,0,0,0,0,0,0] -> outputs all 1. out_valid first high 13 cycles after the last accept; out_last on the 8th output.
- Forward shift: mode 0, input [0,1,0,...,0] -> [1,749,1729,40,3328,2580,1600,3289]. Input all 1 -> [8,0,0,0,0,0,0,0].
- Inverse: mode 1, input all 1 -> [1,0,...,0]. Then a round trip (forward, then inverse) of 200 random frames with values < Q must return the input; the inverse-mode round trip must be exact.
- Reduction and mode latch:
  - In the forward-impulse frame, first coefficient 3330 -> same result as input 1 (all 1).
  - Toggle mode_in after index 0 -> the latched mode is still used.
- Backpressure: out_ready random 50% -> out_data/out_last stable during stalls, order preserved, in_ready stays 0 until the last accept.
- Reset:
  - Assert r for 1 cycle during COMPUTE and again during UNLOAD -> out_valid 0 and in_ready 1 the next cycle.
  - A following fresh frame produces correct results. N=16 and N=256 builds pass the impulse and round-trip tests.
